// File: rtl/race_start_sequencer_pkg.sv
// Shared types for the drag-strip start tree and the timer / best-time / BCD datapath.
package race_start_sequencer_pkg;

  localparam int DISP_W      = 14;    // 4-digit display width, shared with timer, best-time and BCD
  localparam int REACT_LIMIT = 9999;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STAGED = 3'd1,
    S_AMB1   = 3'd2,
    S_AMB2   = 3'd3,
    S_AMB3   = 3'd4,
    S_RUN    = 3'd5,
    S_DONE   = 3'd6,
    S_FOUL   = 3'd7
  } state_e;

  typedef struct packed {
    logic [2:0] amber;
    logic       green;
    logic       red;
    logic       run_en;
  } lights_t;

  function automatic lights_t lights_of(state_e s);
    lights_t l;
    l = '0;
    case (s)
      S_AMB1:  l.amber = 3'b001;
      S_AMB2:  l.amber = 3'b010;
      S_AMB3:  l.amber = 3'b100;
      S_RUN:   begin l.green = 1'b1; l.run_en = 1'b1; end
      S_DONE:  l.green = 1'b1;
      S_FOUL:  l.red   = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/race_start_sequencer_if.sv
// Board-side inputs and light/timer-control outputs of the start sequencer.
interface race_start_sequencer_if;
  import race_start_sequencer_pkg::*;

  logic              tick;
  logic              start_n;
  logic              throttle_n;
  logic              finish;
  logic              crash;
  logic              abort;
  logic [2:0]        amber;
  logic              green;
  logic              red;
  logic              run_en;
  logic              timer_clr;
  logic [DISP_W-1:0] react_time;
  logic              react_valid;
  logic [2:0]        state;

  modport master (
    output tick, start_n, throttle_n, finish, crash, abort,
    input  amber, green, red, run_en, timer_clr, react_time, react_valid, state
  );

  modport slave (
    input  tick, start_n, throttle_n, finish, crash, abort,
    output amber, green, red, run_en, timer_clr, react_time, react_valid, state
  );

endinterface

// File: rtl/race_start_sequencer_btn_sync_edge.sv
// Active-low button: 2-FF synchronizer, then a registered one-cycle press pulse on the falling edge.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin_n,
  output logic o_press
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_press;

  // Flops reset low, so the idle-high pin only ever produces a rising edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_pin_n};
      r_prev  <= r_sync[1];
      r_press <= r_prev & ~r_sync[1];
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/race_start_sequencer.sv
// Christmas-tree sequencer: stage, three ambers, green window, false-start and reaction timing.
module race_start_sequencer
  import race_start_sequencer_pkg::*;
#(
  parameter int STAGE_TICKS = 100,
  parameter int AMBER_TICKS = 50,
  parameter int REACT_MAX   = REACT_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  race_start_sequencer_if.slave  bus
);

  localparam int CNT_MAX = (STAGE_TICKS > AMBER_TICKS) ? STAGE_TICKS : AMBER_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]        w_pin_n;
  logic [1:0]        w_press;
  logic              w_start;
  logic              w_thr;
  logic              w_stg_exp;
  logic              w_amb_exp;
  logic              w_start_acc;
  state_e            w_nxt;

  state_e            r_state;
  lights_t           r_lt;
  logic              r_clr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DISP_W-1:0] r_rt;
  logic              r_rv;

  assign w_pin_n = {bus.throttle_n, bus.start_n};

  btn_sync_edge u_btn [1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin_n (w_pin_n),
    .o_press (w_press)
  );

  assign w_start   = w_press[0];
  assign w_thr     = w_press[1];
  assign w_stg_exp = bus.tick && (r_cnt == CNT_W'(STAGE_TICKS - 1));
  assign w_amb_exp = bus.tick && (r_cnt == CNT_W'(AMBER_TICKS - 1));

  // Throttle during staging beats the amber expiry tick, so a jump on the last tick is a foul.
  always_comb begin
    w_nxt       = r_state;
    w_start_acc = 1'b0;
    if (bus.abort) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FOUL: if (w_start) begin
          w_nxt       = S_STAGED;
          w_start_acc = 1'b1;
        end
        S_STAGED: if (w_thr) w_nxt = S_FOUL; else if (w_stg_exp) w_nxt = S_AMB1;
        S_AMB1:   if (w_thr) w_nxt = S_FOUL; else if (w_amb_exp) w_nxt = S_AMB2;
        S_AMB2:   if (w_thr) w_nxt = S_FOUL; else if (w_amb_exp) w_nxt = S_AMB3;
        S_AMB3:   if (w_thr) w_nxt = S_FOUL; else if (w_amb_exp) w_nxt = S_RUN;
        S_RUN:    if (bus.crash) w_nxt = S_FOUL; else if (bus.finish) w_nxt = S_DONE;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lt    <= '0;
      r_clr   <= 1'b0;
      r_cnt   <= '0;
      r_rt    <= '0;
      r_rv    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_lt    <= lights_of(w_nxt);
      r_clr   <= w_start_acc;
      r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + CNT_W'(bus.tick);
      // A press coinciding with a tick wins, so the pre-increment count is what gets frozen.
      if (bus.abort || w_start_acc) begin
        r_rt <= '0;
        r_rv <= 1'b0;
      end else if (r_state == S_RUN && !r_rv) begin
        if (w_thr)
          r_rv <= 1'b1;
        else if (bus.tick && r_rt != DISP_W'(REACT_MAX))
          r_rt <= r_rt + 1'b1;
      end
    end
  end

  assign bus.amber       = r_lt.amber;
  assign bus.green       = r_lt.green;
  assign bus.red         = r_lt.red;
  assign bus.run_en      = r_lt.run_en;
  assign bus.timer_clr   = r_clr;
  assign bus.react_time  = r_rt;
  assign bus.react_valid = r_rv;
  assign bus.state       = r_state;

endmodule

// File: doc/race_start_sequencer.md
Name: race_start_sequencer

Overview:
Drag-strip "christmas tree" controller that sequences each race for the speed, timer and best-time datapath. It stages the run, steps three amber lights, and opens the green window. It flags a false start if the driver presses throttle early. It measures driver reaction time and gates the run: run_en enables speed stepping and the timer, and timer_clr clears the race timer. It sits between the board buttons/switches and the speed/incrementer blocks at the top level, clocked from CLOCK_50.

Parameters:
STAGE_TICKS, 100, ticks spent in STAGED before the first amber (1 s at 100 Hz tick)
AMBER_TICKS, 50, ticks each amber light is held
REACT_MAX, 9999, saturation value of the reaction counter (4-digit display limit)

Ports:
clk  in  1  system clock (CLOCK_50)
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle enable pulse from the clock divider, the timing base
start_n  in  1  raw start button, active-low, asynchronous to clk
throttle_n  in  1  raw throttle button, active-low, asynchronous to clk
finish  in  1  level from the speed block, high when the car reaches the line
crash  in  1  level from the speed block, engine blown or neutral fault
abort  in  1  synchronous clear, from the race-reset switch
amber  out  3  amber lights, one-hot while sequencing
green  out  1  green light
red  out  1  foul indicator (false start or crash)
run_en  out  1  enables speed stepping and the race timer
timer_clr  out  1  one-cycle pulse that clears the race timer
react_time  out  14  ticks from green to first throttle press, saturating
react_valid  out  1  high once react_time is captured
state  out  3  current state encoding, for LEDs and debug

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0, react_time=0.
  - Tick counter 0, synchronizer flops 0.
- Inputs: start_n and throttle_n pass through a 2-FF synchronizer, then a falling-edge detect.
  - The result is a one-cycle "press" pulse.
  - Press detection therefore lags the pin by 3 clk cycles.
- tick_cnt counts tick pulses only. It clears on every state change.
- States and transitions (registered; outputs are decoded from the registered state):
  - IDLE: all lights off. A start press goes to STAGED and issues timer_clr=1 for exactly 1 cycle. The same cycle clears react_time and react_valid.
  - STAGED: lights off. When tick_cnt reaches STAGE_TICKS (that tick included), go to AMB1.
  - AMB1/AMB2/AMB3: amber=001/010/100. After AMBER_TICKS ticks, step to the next state. AMB3 goes to RUN.
  - A throttle press in STAGED or AMB1..AMB3 goes to FOUL. This includes a press in the same cycle as the AMB3 expiry tick: the foul wins, strict.
  - RUN: green=1, run_en=1, react_time increments on each tick. It saturates at REACT_MAX and never wraps.
  - The first throttle press in RUN freezes react_time and sets react_valid=1. Later presses are ignored.
  - A throttle press in the same cycle as a tick captures the pre-increment value.
  - RUN with finish=1 goes to DONE. RUN with crash=1 goes to FOUL. If both are high in the same cycle, crash has priority.
  - DONE: green=1, run_en=0. react_time and react_valid are held. A start press goes to STAGED, with timer_clr as above.
  - FOUL: red=1, run_en=0, green=0, amber=000. react_time is held (0 if no valid capture). A start press goes to STAGED, with timer_clr.
  - Presses in states not listed above are ignored.
- abort=1 (synchronous) forces IDLE on the next edge from any state. It also clears react_time and react_valid. It has priority over every other event.
- Reset mid-race: run_en drops immediately, asynchronously.
- state encoding: IDLE=0, STAGED=1, AMB1=2, AMB2=3, AMB3=4, RUN=5, DONE=6, FOUL=7.

Decomposition:
- Shared package:
  - state encoding constants (8 values above)
  - REACT_MAX/display limit 9999
  - 14-bit display width constant, reused by the timer, best-time and BCD blocks
- One sub-module: btn_sync_edge (2-FF synchronizer plus falling-edge pulse, active-low input). It is instantiated for start_n and throttle_n.

Test Plan:
All scenarios use STAGE_TICKS=2, AMBER_TICKS=2, tick every 4 clk.
- Clean race: start press, no throttle.
  - Required: timer_clr 1-cycle pulse.
  - Required: amber goes 001 then 010 then 100, each lasting 2 ticks.
  - Required: green=1 and run_en=1 after 8 ticks total.
- Reaction capture: throttle press 5 ticks after green.
  - Required: react_time=5, react_valid=1.
  - Then finish=1 → state=6, run_en=0, react_time still 5.
- False start: throttle press during AMB2.
  - Required: state=7, red=1, amber=000, run_en never asserted.
  - A following start press → state=1 with a timer_clr pulse.
- Boundary: throttle press in the same cycle as the AMB3 expiry tick.
  - Required: FOUL (state=7), green never 1.
- RUN with finish and crash asserted in the same cycle.
  - Required: state=7, red=1.
  - Separately, no throttle for 10000 ticks → react_time=9999 (saturated), react_valid=0.
- Abort and reset.
  - abort=1 during AMB1 → IDLE next edge, all outputs 0.
  - rst_n=0 mid-RUN → run_en=0 immediately, without waiting for a clock edge.
